// File: rtl/commutator_frame_reg_pkg.sv
// Shared helpers and types for the frame-synchronous commutator.
package commutator_frame_reg_pkg;

    // Index width for a set of n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Identity routing used at reset: output k listens to input k mod n.
    function automatic int ident_sel(input int k, input int n);
        return k % n;
    endfunction

    // Classification of a config-port cycle.
    typedef enum logic [1:0] {
        CFG_IDLE    = 2'd0,   // no request
        CFG_ACCEPT  = 2'd1,   // legal write lands in shadow
        CFG_REJECT  = 2'd2,   // out-of-range channel/select, flagged on cfg_err
        CFG_BLOCKED = 2'd3    // commit outstanding, initiator must hold
    } cfg_outcome_e;

endpackage

// File: rtl/commutator_frame_reg_chan.sv
// One output lane: shadow/active routing registers, N-to-1 mux and output register.
module comm_chan_reg
    import commutator_frame_reg_pkg::*;
#(
    parameter int N_IN    = 5,
    parameter int DW      = 1,
    parameter int SEL_W   = 3,
    parameter int RST_SEL = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr,
    input  logic [SEL_W-1:0]     wr_sel,
    input  logic                 wr_en,
    input  logic                 apply,
    input  logic [N_IN*DW-1:0]   in_data,
    output logic [DW-1:0]        out_data,
    output logic                 out_en
);

    localparam logic [SEL_W-1:0] RST_SEL_V = SEL_W'(RST_SEL);

    logic [SEL_W-1:0] shadow_sel_reg;
    logic             shadow_en_reg;
    logic [SEL_W-1:0] act_sel_reg;
    logic             act_en_reg;
    logic [DW-1:0]    out_data_reg;
    logic [DW-1:0]    mux_next;

    // Stage a routing write; the active copy is untouched until apply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_sel_reg <= RST_SEL_V;
            shadow_en_reg  <= 1'b0;
        end else if (wr) begin
            shadow_sel_reg <= wr_sel;
            shadow_en_reg  <= wr_en;
        end
    end

    // Copy shadow to active only on the frame-boundary apply strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_sel_reg <= RST_SEL_V;
            act_en_reg  <= 1'b0;
        end else if (apply) begin
            act_sel_reg <= shadow_sel_reg;
            act_en_reg  <= shadow_en_reg;
        end
    end

    // Select the routed input; a disabled lane or unmatched select yields zero.
    always_comb begin
        mux_next = '0;
        if (act_en_reg) begin
            for (int i = 0; i < N_IN; i++) begin
                if (act_sel_reg == SEL_W'(i)) begin
                    mux_next = in_data[i*DW +: DW];
                end
            end
        end
    end

    // Register the lane output (one cycle of latency from in_data).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg <= '0;
        end else begin
            out_data_reg <= mux_next;
        end
    end

    assign out_data = out_data_reg;
    assign out_en   = act_en_reg;

endmodule

// File: rtl/commutator_frame_reg.sv
// N-input to M-output commutator; routing changes are staged and applied at frame boundaries.
module commutator_frame_reg
    import commutator_frame_reg_pkg::*;
#(
    parameter  int N_IN      = 5,
    parameter  int M_OUT     = 3,
    parameter  int DW        = 1,
    parameter  int FRAME_LEN = 4,
    localparam int SEL_W     = idx_width(N_IN),
    localparam int CH_W      = idx_width(M_OUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic                  cfg_en,
    input  logic                  commit,
    input  logic [N_IN*DW-1:0]    in_data,
    output logic [M_OUT*DW-1:0]   out_data,
    output logic [M_OUT-1:0]      out_en,
    output logic                  frame_start,
    output logic                  pending,
    output logic                  cfg_err
);

    localparam int              CNT_W    = idx_width(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] frame_cnt_reg;
    logic             pending_reg;
    logic             cfg_err_reg;
    logic             cnt_last;
    logic             apply;
    logic             cfg_legal;
    cfg_outcome_e     cfg_outcome;

    assign cnt_last    = (frame_cnt_reg == CNT_LAST);
    assign apply       = pending_reg && cnt_last;
    assign cfg_legal   = (32'(cfg_ch) < M_OUT) && (32'(cfg_sel) < N_IN);

    assign frame_start = (frame_cnt_reg == '0);
    assign pending     = pending_reg;
    assign cfg_ready   = !pending_reg;
    assign cfg_err     = cfg_err_reg;

    // Free-running frame counter, wrapping at FRAME_LEN-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
        end else if (cnt_last) begin
            frame_cnt_reg <= '0;
        end else begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
    end

    // Classify the config request: blocked while a commit is outstanding.
    always_comb begin
        cfg_outcome = CFG_IDLE;
        if (cfg_valid) begin
            if (pending_reg) begin
                cfg_outcome = CFG_BLOCKED;
            end else if (cfg_legal) begin
                cfg_outcome = CFG_ACCEPT;
            end else begin
                cfg_outcome = CFG_REJECT;
            end
        end
    end

    // Pending flag: set by commit when idle, cleared by the boundary apply.
    // A commit seen in the last frame cycle only sets the flag, so it waits a full frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
        end else if (apply) begin
            pending_reg <= 1'b0;
        end else if (commit && !pending_reg) begin
            pending_reg <= 1'b1;
        end
    end

    // One-cycle error pulse for each rejected write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= (cfg_outcome == CFG_REJECT);
        end
    end

    generate
        for (genvar gi = 0; gi < M_OUT; gi++) begin : g_chan
            logic wr_hit;
            assign wr_hit = (cfg_outcome == CFG_ACCEPT) && (cfg_ch == CH_W'(gi));

            comm_chan_reg #(
                .N_IN    (N_IN),
                .DW      (DW),
                .SEL_W   (SEL_W),
                .RST_SEL (ident_sel(gi, N_IN))
            ) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr       (wr_hit),
                .wr_sel   (cfg_sel),
                .wr_en    (cfg_en),
                .apply    (apply),
                .in_data  (in_data),
                .out_data (out_data[gi*DW +: DW]),
                .out_en   (out_en[gi])
            );
        end
    endgenerate

endmodule
